// File: rtl/mac_load_streamer_nch.sv
// N-channel strided TCDM load streamer: each channel issues credit-limited reads,
// buffers responses in a private FIFO and presents them as a valid/ready stream.
module mac_load_streamer_nch #(
    parameter int NB_CH = 2,
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int LEN_W = 16,
    parameter int FD    = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   enable_i,
    input  logic [NB_CH-1:0]       start_i,
    input  logic [NB_CH*AW-1:0]    base_i,
    input  logic [NB_CH*AW-1:0]    stride_i,
    input  logic [NB_CH*LEN_W-1:0] len_i,
    output logic [NB_CH-1:0]       tcdm_req_o,
    input  logic [NB_CH-1:0]       tcdm_gnt_i,
    output logic [NB_CH*AW-1:0]    tcdm_add_o,
    output logic [NB_CH-1:0]       tcdm_wen_o,
    output logic [NB_CH*DW/8-1:0]  tcdm_be_o,
    input  logic [NB_CH*DW-1:0]    tcdm_r_data_i,
    input  logic [NB_CH-1:0]       tcdm_r_valid_i,
    output logic [NB_CH-1:0]       strm_valid_o,
    input  logic [NB_CH-1:0]       strm_ready_i,
    output logic [NB_CH*DW-1:0]    strm_data_o,
    output logic [NB_CH-1:0]       done_o,
    output logic                   busy_o
);

    localparam int CW = $clog2(FD + 1);
    localparam int PW = (FD > 1) ? $clog2(FD) : 1;
    localparam logic [CW:0]   FD_CREDIT = (CW + 1)'(FD);
    localparam logic [CW-1:0] FD_OCC    = CW'(FD);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [NB_CH-1:0] busy_ch;

    assign busy_o = |busy_ch;

    for (genvar g = 0; g < NB_CH; g++) begin : g_ch
        state_t               state_q, state_d;
        logic [AW-1:0]        addr_q;
        logic signed [AW-1:0] stride_q;
        logic [LEN_W-1:0]     len_q, issued_q, len_in;
        logic [CW-1:0]        inflight_q, inflight_d, occ_q;
        logic [PW-1:0]        wptr_q, rptr_q;
        logic [DW-1:0]        fifo_q [FD];
        logic                 done_q, done_d;
        logic                 start, req, issue, resp, push, pop, valid, drained;
        logic [CW:0]          credit;

        assign len_in  = len_i[g*LEN_W +: LEN_W];
        assign valid   = (occ_q != '0);
        // Every granted word holds a credit until it leaves the FIFO, so the FIFO cannot overflow.
        assign credit  = {1'b0, occ_q} + {1'b0, inflight_q};
        assign start   = start_i[g] & ~clear_i & (state_q == IDLE);
        assign req     = (state_q == RUN) & enable_i & ~clear_i &
                         (issued_q < len_q) & (credit < FD_CREDIT);
        assign issue   = req & tcdm_gnt_i[g];
        assign resp    = tcdm_r_valid_i[g] & (state_q != IDLE);
        assign push    = resp & (state_q == RUN) & ~clear_i;
        assign pop     = valid & strm_ready_i[g] & ~clear_i;
        assign drained = (issued_q == len_q) & (inflight_q == '0) &
                         ((occ_q == '0) | ((occ_q == CW'(1)) & pop));
        assign inflight_d = inflight_q + CW'(issue) - CW'(resp);

        always_comb begin
            state_d = state_q;
            done_d  = 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (len_in == '0) done_d  = 1'b1;
                        else              state_d = RUN;
                    end
                end
                RUN: begin
                    if (clear_i) begin
                        state_d = (inflight_d != '0) ? FLUSH : IDLE;
                    end else if (drained) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                FLUSH: begin
                    if (inflight_d == '0) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                state_q    <= IDLE;
                done_q     <= 1'b0;
                inflight_q <= '0;
                occ_q      <= '0;
                wptr_q     <= '0;
                rptr_q     <= '0;
                issued_q   <= '0;
                len_q      <= '0;
                addr_q     <= '0;
            end else begin
                state_q    <= state_d;
                done_q     <= done_d;
                inflight_q <= inflight_d;
                if (clear_i) begin
                    occ_q  <= '0;
                    wptr_q <= '0;
                    rptr_q <= '0;
                end else begin
                    occ_q <= occ_q + CW'(push) - CW'(pop);
                    if (push) wptr_q <= ptr_inc(wptr_q);
                    if (pop)  rptr_q <= ptr_inc(rptr_q);
                end
                if (start) begin
                    addr_q   <= base_i[g*AW +: AW];
                    len_q    <= len_in;
                    issued_q <= '0;
                end else if (issue) begin
                    addr_q   <= addr_q + stride_q;
                    issued_q <= issued_q + LEN_W'(1);
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (start) stride_q <= $signed(stride_i[g*AW +: AW]);
            if (push)  fifo_q[wptr_q] <= tcdm_r_data_i[g*DW +: DW];
        end

        a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
            !(push && !pop && (occ_q == FD_OCC)));

        assign tcdm_req_o[g]              = req;
        assign tcdm_add_o[g*AW +: AW]     = addr_q;
        assign tcdm_wen_o[g]              = 1'b1;
        assign tcdm_be_o[g*DW/8 +: DW/8]  = '1;
        assign strm_valid_o[g]            = valid;
        assign strm_data_o[g*DW +: DW]    = valid ? fifo_q[rptr_q] : '0;
        assign done_o[g]                  = done_q;
        assign busy_ch[g]                 = (state_q != IDLE);
    end

endmodule

// File: tb/tb_mac_load_streamer_nch.sv
// Scoreboard bench for mac_load_streamer_nch: directed transfers, a TCDM memory
// responder with controllable grant/ready/response behaviour, and a decoupled monitor.
module tb_mac_load_streamer_nch;

    localparam int NB_CH = 2;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int LEN_W = 16;
    localparam int FD    = 4;

    logic                   clk = 1'b0;
    logic                   rst_ni;
    logic                   clear;
    logic                   enable;
    logic [NB_CH-1:0]       start;
    logic [NB_CH*AW-1:0]    base;
    logic [NB_CH*AW-1:0]    stride;
    logic [NB_CH*LEN_W-1:0] len;
    logic [NB_CH-1:0]       req;
    logic [NB_CH-1:0]       gnt;
    logic [NB_CH*AW-1:0]    add;
    logic [NB_CH-1:0]       wen;
    logic [NB_CH*DW/8-1:0]  be;
    logic [NB_CH*DW-1:0]    r_data;
    logic [NB_CH-1:0]       r_valid;
    logic [NB_CH-1:0]       valid;
    logic [NB_CH-1:0]       ready;
    logic [NB_CH*DW-1:0]    data;
    logic [NB_CH-1:0]       done;
    logic                   busy;

    mac_load_streamer_nch #(
        .NB_CH(NB_CH), .DW(DW), .AW(AW), .LEN_W(LEN_W), .FD(FD)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear), .enable_i(enable),
        .start_i(start), .base_i(base), .stride_i(stride), .len_i(len),
        .tcdm_req_o(req), .tcdm_gnt_i(gnt), .tcdm_add_o(add), .tcdm_wen_o(wen),
        .tcdm_be_o(be), .tcdm_r_data_i(r_data), .tcdm_r_valid_i(r_valid),
        .strm_valid_o(valid), .strm_ready_i(ready), .strm_data_o(data),
        .done_o(done), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared   = 0;
    int mismatched = 0;

    // Environment controls: mode 0 = never, 1 = always, 2 = random.
    int          gnt_mode [NB_CH];
    int          rdy_mode [NB_CH];
    bit          hold     [NB_CH];
    bit          resp_rand;

    logic [31:0] exp_addr_q [NB_CH][$];
    logic [31:0] exp_data_q [NB_CH][$];
    logic [31:0] pend_q     [NB_CH][$];
    int          grant_cnt  [NB_CH];
    int          pop_cnt    [NB_CH];
    int          done_seen  [NB_CH];
    int          done_cyc   [NB_CH];
    int          max_out    [NB_CH];
    logic [31:0] last_addr  [NB_CH];
    bit          busy_seen;

    function automatic logic [31:0] mem_word(int c, logic [31:0] a);
        return {a[15:0], 8'(c + 1), ~a[7:0]};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_event(string name, logic [63:0] act);
        compared++;
        mismatched++;
        $display("FAIL %s: unexpected event, value 0x%0h", name, act);
    endtask

    // TCDM side: grants, in-order responses from the memory model, stream ready.
    always begin
        @(posedge clk);
        #4;
        for (int c = 0; c < NB_CH; c++) begin
            case (gnt_mode[c])
                0:       gnt[c] = 1'b0;
                1:       gnt[c] = 1'b1;
                default: gnt[c] = 1'($urandom_range(0, 1));
            endcase
            case (rdy_mode[c])
                0:       ready[c] = 1'b0;
                1:       ready[c] = 1'b1;
                default: ready[c] = 1'($urandom_range(0, 1));
            endcase
            if (!hold[c] && pend_q[c].size() != 0 && (!resp_rand || $urandom_range(0, 1) == 1)) begin
                r_valid[c]             = 1'b1;
                r_data[c*DW +: DW]     = mem_word(c, pend_q[c].pop_front());
            end else begin
                r_valid[c]             = 1'b0;
                r_data[c*DW +: DW]     = '0;
            end
        end
    end

    // Monitor: observes settled handshakes just before each edge.
    always begin
        logic [31:0] a;
        @(posedge clk);
        #8;
        if (rst_ni) begin
            for (int c = 0; c < NB_CH; c++) begin
                if (req[c] && gnt[c]) begin
                    a = add[c*AW +: AW];
                    grant_cnt[c]++;
                    last_addr[c] = a;
                    pend_q[c].push_back(a);
                    if (exp_addr_q[c].size() == 0)
                        fail_event($sformatf("grant ch%0d", c), 64'(a));
                    else
                        check($sformatf("addr ch%0d #%0d", c, grant_cnt[c] - 1), 64'(a),
                              64'(exp_addr_q[c].pop_front()));
                end
                if (valid[c] && ready[c]) begin
                    pop_cnt[c]++;
                    if (exp_data_q[c].size() == 0)
                        fail_event($sformatf("stream ch%0d", c), 64'(data[c*DW +: DW]));
                    else
                        check($sformatf("data ch%0d #%0d", c, pop_cnt[c] - 1),
                              64'(data[c*DW +: DW]), 64'(exp_data_q[c].pop_front()));
                end
                if (grant_cnt[c] - pop_cnt[c] > max_out[c]) max_out[c] = grant_cnt[c] - pop_cnt[c];
                if (done[c]) begin
                    done_seen[c]++;
                    done_cyc[c] = cyc;
                end
            end
            if (busy) busy_seen = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic start_ch(int c, logic [31:0] b, logic [31:0] s, int n);
        logic [31:0] a;
        base[c*AW +: AW]      = b;
        stride[c*AW +: AW]    = s;
        len[c*LEN_W +: LEN_W] = LEN_W'(n);
        start[c]              = 1'b1;
        for (int i = 0; i < n; i++) begin
            a = b + s * 32'(i);
            exp_addr_q[c].push_back(a);
            exp_data_q[c].push_back(mem_word(c, a));
        end
    endtask

    task automatic pulse();
        step();
        start = '0;
    endtask

    task automatic reset_stats();
        for (int c = 0; c < NB_CH; c++) begin
            grant_cnt[c] = 0;
            pop_cnt[c]   = 0;
            done_seen[c] = 0;
            done_cyc[c]  = 0;
            max_out[c]   = 0;
        end
        busy_seen = 1'b0;
    endtask

    task automatic wait_done(int c, int target, int budget, string name);
        int k;
        k = 0;
        while (done_seen[c] < target && k < budget) begin
            step();
            k++;
        end
        if (done_seen[c] < target) fail_event({name, " done timeout"}, 64'(done_seen[c]));
    endtask

    task automatic end_test(string name);
        for (int c = 0; c < NB_CH; c++) begin
            check($sformatf("%s addr left ch%0d", name, c), 64'(exp_addr_q[c].size()), 64'd0);
            check($sformatf("%s data left ch%0d", name, c), 64'(exp_data_q[c].size()), 64'd0);
            check($sformatf("%s resp left ch%0d", name, c), 64'(pend_q[c].size()), 64'd0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int k;
        rst_ni = 1'b0; clear = 1'b0; enable = 1'b0; start = '0;
        base = '0; stride = '0; len = '0;
        gnt = '0; ready = '0; r_valid = '0; r_data = '0;
        resp_rand = 1'b0;
        for (int c = 0; c < NB_CH; c++) begin
            gnt_mode[c] = 1;
            rdy_mode[c] = 1;
            hold[c]     = 1'b0;
        end
        reset_stats();

        repeat (3) @(posedge clk);
        #8;
        check("reset req",   64'(req),   64'd0);
        check("reset valid", 64'(valid), 64'd0);
        check("reset done",  64'(done),  64'd0);
        check("reset busy",  64'(busy),  64'd0);
        check("reset add",   64'(add),   64'd0);
        check("reset data",  64'(data),  64'd0);
        check("reset wen",   64'(wen),   64'h3);
        check("reset be",    64'(be),    64'hFF);
        step();
        rst_ni = 1'b1;
        enable = 1'b1;
        step();

        // T1: 0x100..0x11C, full throughput, ch1 untouched.
        reset_stats();
        t0 = cyc;
        start_ch(0, 32'h100, 32'd4, 8);
        pulse();
        wait_done(0, 1, 50, "T1");
        // start edge + 8 grants + response + pop => done visible 11 cycles after the start drive
        check("T1 done latency", 64'(done_cyc[0] - t0), 64'd11);
        repeat (3) step();
        check("T1 last addr",  64'(last_addr[0]), 64'h11C);
        check("T1 grants ch0", 64'(grant_cnt[0]), 64'd8);
        check("T1 pops ch0",   64'(pop_cnt[0]),   64'd8);
        check("T1 done ch0",   64'(done_seen[0]), 64'd1);
        check("T1 grants ch1", 64'(grant_cnt[1]), 64'd0);
        check("T1 done ch1",   64'(done_seen[1]), 64'd0);
        end_test("T1");

        // T2: stalled consumer limits outstanding reads to FD.
        reset_stats();
        rdy_mode[0] = 0;
        start_ch(0, 32'h400, 32'd4, 10);
        pulse();
        repeat (20) step();
        #6;
        check("T2 stalled grants", 64'(grant_cnt[0]), 64'd4);
        check("T2 stalled req",    64'(req[0]),       64'd0);
        check("T2 stalled valid",  64'(valid[0]),     64'd1);
        step();
        rdy_mode[0] = 1;
        wait_done(0, 1, 100, "T2");
        check("T2 grants",   64'(grant_cnt[0]), 64'd10);
        check("T2 pops",     64'(pop_cnt[0]),   64'd10);
        check("T2 max occ",  64'(max_out[0]),   64'd4);
        end_test("T2");

        // T3: negative stride wraps below zero.
        reset_stats();
        start_ch(0, 32'h8, 32'hFFFF_FFFC, 4);
        pulse();
        wait_done(0, 1, 50, "T3");
        check("T3 last addr", 64'(last_addr[0]), 64'hFFFF_FFFC);
        check("T3 grants",    64'(grant_cnt[0]), 64'd4);
        end_test("T3");

        // T4: zero-length start.
        repeat (2) step();
        reset_stats();
        start_ch(0, 32'h40, 32'd4, 0);
        pulse();
        #6;
        check("T4 done pulse", 64'(done[0]), 64'd1);
        check("T4 req",        64'(req[0]),  64'd0);
        check("T4 busy",       64'(busy),    64'd0);
        repeat (3) step();
        check("T4 done count", 64'(done_seen[0]), 64'd1);
        check("T4 busy seen",  64'(busy_seen),    64'd0);
        check("T4 grants",     64'(grant_cnt[0]), 64'd0);
        end_test("T4");

        // T5: both channels with random grant, ready and response timing.
        reset_stats();
        resp_rand = 1'b1;
        for (int c = 0; c < NB_CH; c++) begin
            gnt_mode[c] = 2;
            rdy_mode[c] = 2;
        end
        start_ch(0, 32'h1000, 32'd4, 64);
        start_ch(1, 32'h2000_0000, 32'hFFFF_FFF8, 64);
        pulse();
        wait_done(0, 1, 3000, "T5 ch0");
        wait_done(1, 1, 3000, "T5 ch1");
        repeat (3) step();
        check("T5 grants ch0", 64'(grant_cnt[0]), 64'd64);
        check("T5 grants ch1", 64'(grant_cnt[1]), 64'd64);
        check("T5 pops ch0",   64'(pop_cnt[0]),   64'd64);
        check("T5 pops ch1",   64'(pop_cnt[1]),   64'd64);
        check("T5 done ch0",   64'(done_seen[0]), 64'd1);
        check("T5 done ch1",   64'(done_seen[1]), 64'd1);
        check("T5 last ch1",   64'(last_addr[1]), 64'h1FFF_FE08);
        resp_rand = 1'b0;
        for (int c = 0; c < NB_CH; c++) begin
            gnt_mode[c] = 1;
            rdy_mode[c] = 1;
        end
        end_test("T5");

        // T6: clear with two reads in flight, then a fresh transfer.
        reset_stats();
        hold[0] = 1'b1;
        start_ch(0, 32'h300, 32'd4, 8);
        pulse();
        k = 0;
        while (grant_cnt[0] < 2 && k < 20) begin
            step();
            k++;
        end
        gnt_mode[0] = 0;
        clear = 1'b1;
        #6;
        check("T6 req on clear", 64'(req[0]), 64'd0);
        step();
        clear = 1'b0;
        exp_addr_q[0].delete();
        exp_data_q[0].delete();
        #6;
        check("T6 flush busy",  64'(busy),         64'd1);
        check("T6 flush valid", 64'(valid[0]),     64'd0);
        check("T6 in flight",   64'(grant_cnt[0]), 64'd2);
        step();
        hold[0] = 1'b0;
        k = 0;
        while (busy && k < 20) begin
            step();
            k++;
        end
        repeat (2) step();
        check("T6 idle",       64'(busy),           64'd0);
        check("T6 stale resp", 64'(pend_q[0].size()), 64'd0);
        check("T6 no done",    64'(done_seen[0]),   64'd0);
        check("T6 no pops",    64'(pop_cnt[0]),     64'd0);
        gnt_mode[0] = 1;
        reset_stats();
        start_ch(0, 32'h200, 32'd4, 2);
        pulse();
        wait_done(0, 1, 50, "T6");
        repeat (2) step();
        check("T6 new grants", 64'(grant_cnt[0]), 64'd2);
        check("T6 new pops",   64'(pop_cnt[0]),   64'd2);
        check("T6 new last",   64'(last_addr[0]), 64'h204);
        end_test("T6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
